// File: rtl/mpm_wport_feeder.sv
// mpm_wport_feeder: write-side feeder for one MPM write port.
// Takes a packet word stream, prefetches one free page, drives the MPM
// write port with per-word page addresses, builds the page chain in the
// linked-list memory and reports each finished packet (start page, length).
module mpm_wport_feeder #(
  parameter int g_data_width      = 18,
  parameter int g_page_size       = 64,
  parameter int g_page_addr_width = 10
) (
  input  logic                         clk_core_i,
  input  logic                         rst_n_i,
  input  logic [g_data_width-1:0]      snk_data_i,
  input  logic                         snk_valid_i,
  input  logic                         snk_sop_i,
  input  logic                         snk_eop_i,
  output logic                         snk_ready_o,
  output logic                         alloc_req_o,
  input  logic                         alloc_done_i,
  input  logic [g_page_addr_width-1:0] alloc_pg_i,
  output logic [g_data_width-1:0]      mpm_d_o,
  output logic                         mpm_dvalid_o,
  output logic                         mpm_dlast_o,
  output logic [g_page_addr_width-1:0] mpm_pg_addr_o,
  input  logic                         mpm_dreq_i,
  input  logic                         mpm_pg_req_i,
  output logic                         ll_wr_o,
  output logic [g_page_addr_width-1:0] ll_addr_o,
  output logic [g_page_addr_width:0]   ll_data_o,
  output logic                         pck_valid_o,
  output logic [g_page_addr_width-1:0] pck_pg_o,
  output logic [15:0]                  pck_words_o,
  output logic                         err_o
);

  localparam int AW = g_page_addr_width;
  localparam int CW = $clog2(g_page_size + 1);
  localparam logic [CW-1:0] PageSize = CW'(g_page_size);
  localparam logic [CW-1:0] OneWord  = CW'(1);

  typedef enum logic {IDLE = 1'b0, PCK = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    slot_full_q, slot_full_d;
  logic [AW-1:0]           slot_pg_q, slot_pg_d;
  logic                    alloc_req_q;
  logic [AW-1:0]           cur_pg_q, cur_pg_d;
  logic [AW-1:0]           start_pg_q, start_pg_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic [15:0]             words_q, words_d;
  logic [AW-1:0]           done_pg_q;
  logic [15:0]             done_words_q;
  logic [g_data_width-1:0] d_q;
  logic                    dvalid_q, dlast_q, pgend_q;
  logic [AW-1:0]           pg_q;
  logic                    ll_wr_q;
  logic [AW-1:0]           ll_addr_q;
  logic [AW:0]             ll_data_q;
  logic                    eop_pend_q;
  logic [AW-1:0]           eop_addr_q;
  logic [AW:0]             eop_data_q;
  logic                    pck_valid_q;
  logic [AW-1:0]           pck_pg_q;
  logic [15:0]             pck_words_q;
  logic                    err_q, err_d;

  logic          free, xfer, page_full, need_page, ready, accept;
  logic          in_idle, start_acc, body_acc, switch_pg, take_slot, load_word, eop_acc;
  logic [AW-1:0] word_pg;

  // Handshake decode: where the incoming word goes and whether it may enter now
  always_comb begin
    free      = ~dvalid_q | mpm_dreq_i;
    xfer      = dvalid_q & mpm_dreq_i;
    in_idle   = (state_q == IDLE);
    page_full = (wcnt_q == PageSize);
    need_page = in_idle | page_full;
    ready     = rst_n_i & free & (need_page ? slot_full_q : 1'b1);
    accept    = snk_valid_i & ready;
    start_acc = accept & in_idle & snk_sop_i;
    body_acc  = accept & ~in_idle;
    switch_pg = body_acc & page_full;
    take_slot = start_acc | switch_pg;
    load_word = start_acc | body_acc;
    eop_acc   = load_word & snk_eop_i;
    word_pg   = take_slot ? slot_pg_q : cur_pg_q;
  end

  // Next-state for packet tracking, prefetch slot and the sticky error flag
  always_comb begin
    state_d    = state_q;
    cur_pg_d   = cur_pg_q;
    start_pg_d = start_pg_q;
    wcnt_d     = wcnt_q;
    words_d    = words_q;
    slot_full_d = slot_full_q;
    slot_pg_d   = slot_pg_q;
    if (start_acc) begin
      start_pg_d = slot_pg_q;
      cur_pg_d   = slot_pg_q;
      wcnt_d     = OneWord;
      words_d    = 16'd1;
      state_d    = snk_eop_i ? IDLE : PCK;
    end else if (body_acc) begin
      if (page_full) begin
        cur_pg_d = slot_pg_q;
        wcnt_d   = OneWord;
      end else begin
        wcnt_d = wcnt_q + OneWord;
      end
      if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
      if (snk_eop_i) state_d = IDLE;
    end
    if (take_slot) slot_full_d = 1'b0;
    if (alloc_done_i & ~slot_full_q) begin
      slot_full_d = 1'b1;
      slot_pg_d   = alloc_pg_i;
    end
    err_d = err_q
          | (alloc_done_i & slot_full_q)
          | (accept & in_idle & ~snk_sop_i)
          | (body_acc & snk_sop_i)
          | (mpm_pg_req_i & ~(xfer & (pgend_q | dlast_q)));
  end

  // Prefetch slot: keep one free page ready, requesting whenever the slot is empty
  always_ff @(posedge clk_core_i) begin
    if (!rst_n_i) begin
      slot_full_q <= 1'b0;
      slot_pg_q   <= '0;
      alloc_req_q <= 1'b0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_pg_q   <= slot_pg_d;
      alloc_req_q <= ~slot_full_d;
    end
  end

  // Packet FSM with page word counter, length counter and completion snapshot
  always_ff @(posedge clk_core_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cur_pg_q     <= '0;
      start_pg_q   <= '0;
      wcnt_q       <= '0;
      words_q      <= '0;
      done_pg_q    <= '0;
      done_words_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_pg_q   <= cur_pg_d;
      start_pg_q <= start_pg_d;
      wcnt_q     <= wcnt_d;
      words_q    <= words_d;
      if (eop_acc) begin
        done_pg_q    <= start_pg_d;
        done_words_q <= words_d;
      end
    end
  end

  // One-deep MPM output register; a word is held until the MPM takes it
  always_ff @(posedge clk_core_i) begin
    if (!rst_n_i) begin
      d_q      <= '0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      pgend_q  <= 1'b0;
      pg_q     <= '0;
    end else if (load_word) begin
      d_q      <= snk_data_i;
      dvalid_q <= 1'b1;
      dlast_q  <= snk_eop_i;
      pgend_q  <= (wcnt_d == PageSize);
      pg_q     <= word_pg;
    end else if (xfer) begin
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      pgend_q  <= 1'b0;
    end
  end

  // Linked-list writer; an eop write colliding with a page-switch write waits one cycle
  always_ff @(posedge clk_core_i) begin
    if (!rst_n_i) begin
      ll_wr_q    <= 1'b0;
      ll_addr_q  <= '0;
      ll_data_q  <= '0;
      eop_pend_q <= 1'b0;
      eop_addr_q <= '0;
      eop_data_q <= '0;
    end else begin
      ll_wr_q <= 1'b0;
      if (eop_pend_q) begin
        ll_wr_q    <= 1'b1;
        ll_addr_q  <= eop_addr_q;
        ll_data_q  <= eop_data_q;
        eop_pend_q <= 1'b0;
      end else if (switch_pg) begin
        ll_wr_q   <= 1'b1;
        ll_addr_q <= cur_pg_q;
        ll_data_q <= {1'b0, slot_pg_q};
        if (snk_eop_i) begin
          eop_pend_q <= 1'b1;
          eop_addr_q <= slot_pg_q;
          eop_data_q <= {1'b1, AW'(wcnt_d)};
        end
      end else if (eop_acc) begin
        ll_wr_q   <= 1'b1;
        ll_addr_q <= word_pg;
        ll_data_q <= {1'b1, AW'(wcnt_d)};
      end
    end
  end

  // Completion pulse after the eop word leaves, plus the sticky error flag
  always_ff @(posedge clk_core_i) begin
    if (!rst_n_i) begin
      pck_valid_q <= 1'b0;
      pck_pg_q    <= '0;
      pck_words_q <= '0;
      err_q       <= 1'b0;
    end else begin
      pck_valid_q <= xfer & dlast_q;
      if (xfer & dlast_q) begin
        pck_pg_q    <= done_pg_q;
        pck_words_q <= done_words_q;
      end
      err_q <= err_d;
    end
  end

  assign snk_ready_o   = ready;
  assign alloc_req_o   = alloc_req_q;
  assign mpm_d_o       = d_q;
  assign mpm_dvalid_o  = dvalid_q;
  assign mpm_dlast_o   = dlast_q;
  assign mpm_pg_addr_o = pg_q;
  assign ll_wr_o       = ll_wr_q;
  assign ll_addr_o     = ll_addr_q;
  assign ll_data_o     = ll_data_q;
  assign pck_valid_o   = pck_valid_q;
  assign pck_pg_o      = pck_pg_q;
  assign pck_words_o   = pck_words_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mpm_wport_feeder.sv
// tb_mpm_wport_feeder: directed scoreboard bench for mpm_wport_feeder with
// 4-word pages; a model allocator grants pages from a per-test list.
module tb_mpm_wport_feeder;

  localparam int DW = 18;
  localparam int PS = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] snkData;
  logic          snkValid, snkSop, snkEop, snkReady;
  logic          allocReq, allocDone;
  logic [AW-1:0] allocPg;
  logic [DW-1:0] mpmD;
  logic          mpmDvalid, mpmDlast, mpmDreq, mpmPgReq;
  logic [AW-1:0] mpmPgAddr;
  logic          llWr;
  logic [AW-1:0] llAddr;
  logic [AW:0]   llData;
  logic          pckValid;
  logic [AW-1:0] pckPg;
  logic [15:0]   pckWords;
  logic          errO;

  int errors = 0;
  int checks = 0;
  logic [127:0] expWordQ[$];
  logic [127:0] expLlQ[$];
  logic [127:0] expPckQ[$];
  int pageList[8];
  int delayList[8];
  int pidx = 0;
  int latCnt = 0;
  bit dreqToggle = 1'b0;
  int waits[16];
  bit prevHold = 1'b0;
  logic [127:0] prevWord = '0;
  logic [127:0] curWord;

  always #5 clk = ~clk;

  mpm_wport_feeder #(
    .g_data_width(DW), .g_page_size(PS), .g_page_addr_width(AW)
  ) dut (
    .clk_core_i(clk), .rst_n_i(rst_n),
    .snk_data_i(snkData), .snk_valid_i(snkValid), .snk_sop_i(snkSop),
    .snk_eop_i(snkEop), .snk_ready_o(snkReady),
    .alloc_req_o(allocReq), .alloc_done_i(allocDone), .alloc_pg_i(allocPg),
    .mpm_d_o(mpmD), .mpm_dvalid_o(mpmDvalid), .mpm_dlast_o(mpmDlast),
    .mpm_pg_addr_o(mpmPgAddr), .mpm_dreq_i(mpmDreq), .mpm_pg_req_i(mpmPgReq),
    .ll_wr_o(llWr), .ll_addr_o(llAddr), .ll_data_o(llData),
    .pck_valid_o(pckValid), .pck_pg_o(pckPg), .pck_words_o(pckWords),
    .err_o(errO)
  );

  function automatic logic [127:0] wordExp(input int pg, input int data, input bit last);
    return 128'({AW'(pg), last, DW'(data)});
  endfunction

  function automatic logic [127:0] llExp(input int addr, input bit eop, input int val);
    return 128'({AW'(addr), eop, AW'(val)});
  endfunction

  function automatic logic [127:0] pckExp(input int pg, input int words);
    return 128'({AW'(pg), 16'(words)});
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [127:0] got);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h, required nothing", name, got);
  endtask

  // Model page allocator: one grant per request after 1 + delayList[] cycles
  initial begin
    allocDone = 1'b0;
    allocPg   = '0;
    forever begin
      @(posedge clk);
      #2;
      allocDone = 1'b0;
      if (!rst_n) begin
        pidx   = 0;
        latCnt = 0;
      end else if (allocReq && pidx < 8) begin
        if (latCnt < 1 + delayList[pidx]) latCnt++;
        else begin
          allocDone = 1'b1;
          allocPg   = AW'(pageList[pidx]);
          pidx++;
          latCnt = 0;
        end
      end else begin
        latCnt = 0;
      end
    end
  end

  // MPM accept pattern: always ready, or alternating 1/0 every cycle
  initial begin
    mpmDreq = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mpmDreq = dreqToggle ? ~mpmDreq : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a word, ll write or report
  always @(negedge clk) begin
    curWord = 128'({mpmPgAddr, mpmDlast, mpmD});
    if (prevHold && mpmDvalid) checkOutput("hold_stable", curWord, prevWord);
    prevHold = mpmDvalid && !mpmDreq;
    prevWord = curWord;
    if (mpmDvalid && mpmDreq) begin
      if (expWordQ.size() == 0) reportUnexpected("mpm_word", curWord);
      else checkOutput("mpm_word", curWord, expWordQ.pop_front());
    end
    if (llWr) begin
      if (expLlQ.size() == 0) reportUnexpected("ll_write", 128'({llAddr, llData}));
      else checkOutput("ll_write", 128'({llAddr, llData}), expLlQ.pop_front());
    end
    if (pckValid) begin
      if (expPckQ.size() == 0) reportUnexpected("pck_report", 128'({pckPg, pckWords}));
      else checkOutput("pck_report", 128'({pckPg, pckWords}), expPckQ.pop_front());
    end
  end

  task automatic setPages(input int stall);
    for (int i = 0; i < 8; i++) begin
      pageList[i]  = 5 + 4 * i;
      delayList[i] = 0;
    end
    pageList[1]  = 9;
    delayList[1] = stall;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs",
                128'({snkReady, allocReq, mpmD, mpmDvalid, mpmDlast, mpmPgAddr, llWr,
                      llAddr, llData, pckValid, pckPg, pckWords, errO}), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int data, input bit sop, input bit eop, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    snkData = DW'(data);
    snkSop = sop;
    snkEop = eop;
    snkValid = 1'b1;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = snkReady;
      @(posedge clk);
      #1;
      waited++;
    end
    snkValid = 1'b0;
    snkSop = 1'b0;
    snkEop = 1'b0;
    checkOutput("word_accepted", 128'(acc), 128'(1));
  endtask

  task automatic sendPacket(input int base, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      applyStimulus(base + i, i == 0, i == n - 1, w);
      waits[i] = w;
    end
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((expWordQ.size() + expLlQ.size() + expPckQ.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput({tag, "_drained"},
                128'(expWordQ.size() + expLlQ.size() + expPckQ.size()), 128'(0));
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int w;
    snkData = '0; snkValid = 1'b0; snkSop = 1'b0; snkEop = 1'b0;
    mpmPgReq = 1'b0; rst_n = 1'b0;
    setPages(0);
    @(posedge clk);
    #1;

    $display("[TB] test 1: 3-word packet on one page");
    applyReset();
    for (int i = 0; i < 3; i++) expWordQ.push_back(wordExp(5, 'h100 + i, i == 2));
    expLlQ.push_back(llExp(5, 1'b1, 3));
    expPckQ.push_back(pckExp(5, 3));
    sendPacket('h100, 3);
    waitDrain("t1");
    checkOutput("t1_err", 128'(errO), 128'(0));

    $display("[TB] test 2: 6-word packet across a page boundary");
    applyReset();
    for (int i = 0; i < 6; i++) expWordQ.push_back(wordExp(i < 4 ? 5 : 9, 'h200 + i, i == 5));
    expLlQ.push_back(llExp(5, 1'b0, 9));
    expLlQ.push_back(llExp(9, 1'b1, 2));
    expPckQ.push_back(pckExp(5, 6));
    sendPacket('h200, 6);
    waitDrain("t2");
    checkOutput("t2_err", 128'(errO), 128'(0));

    $display("[TB] test 3: allocator stall at the page boundary");
    setPages(10);
    applyReset();
    for (int i = 0; i < 5; i++) expWordQ.push_back(wordExp(i < 4 ? 5 : 9, 'h300 + i, i == 4));
    expLlQ.push_back(llExp(5, 1'b0, 9));
    expLlQ.push_back(llExp(9, 1'b1, 1));
    expPckQ.push_back(pckExp(5, 5));
    sendPacket('h300, 5);
    for (int i = 1; i < 4; i++) checkOutput("t3_no_gap_wait", 128'(waits[i]), 128'(1));
    checkOutput("t3_stalled_word5", 128'(waits[4] > 3), 128'(1));
    waitDrain("t3");
    setPages(0);

    $display("[TB] test 4: dreq toggling over a 4-word packet");
    applyReset();
    for (int i = 0; i < 4; i++) expWordQ.push_back(wordExp(5, 'h400 + i, i == 3));
    expLlQ.push_back(llExp(5, 1'b1, 4));
    expPckQ.push_back(pckExp(5, 4));
    dreqToggle = 1'b1;
    sendPacket('h400, 4);
    waitDrain("t4");
    dreqToggle = 1'b0;
    checkOutput("t4_err", 128'(errO), 128'(0));

    $display("[TB] test 5: back-to-back single-word packets");
    applyReset();
    expWordQ.push_back(wordExp(5, 'h501, 1'b1));
    expWordQ.push_back(wordExp(9, 'h502, 1'b1));
    expLlQ.push_back(llExp(5, 1'b1, 1));
    expLlQ.push_back(llExp(9, 1'b1, 1));
    expPckQ.push_back(pckExp(5, 1));
    expPckQ.push_back(pckExp(9, 1));
    applyStimulus('h501, 1'b1, 1'b1, w);
    applyStimulus('h502, 1'b1, 1'b1, w);
    waitDrain("t5");
    checkOutput("t5_err", 128'(errO), 128'(0));

    $display("[TB] test 6: protocol errors and reset mid-packet");
    applyReset();
    applyStimulus('h600, 1'b0, 1'b0, w);
    @(posedge clk);
    #1;
    checkOutput("err_nonsop", 128'(errO), 128'(1));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("err_sticky_nonsop", 128'(errO), 128'(1));
    waitDrain("t6a");

    applyReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("err_after_reset", 128'(errO), 128'(0));
    mpmPgReq = 1'b1;
    @(posedge clk);
    #1;
    mpmPgReq = 1'b0;
    checkOutput("err_stray_pgreq", 128'(errO), 128'(1));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("err_sticky_pgreq", 128'(errO), 128'(1));

    applyReset();
    expWordQ.push_back(wordExp(5, 'h610, 1'b0));
    expWordQ.push_back(wordExp(5, 'h611, 1'b0));
    applyStimulus('h610, 1'b1, 1'b0, w);
    applyStimulus('h611, 1'b0, 1'b0, w);
    applyReset();
    w = 0;
    while (!allocReq && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("fresh_alloc_req", 128'(allocReq), 128'(1));
    waitDrain("t6c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
